// File: rtl/sram_loader_pkg.sv
// Shared types and constants for the SRAM host-port loader.
// The timer is sized for phase lengths of up to 2**TMR_W cycles.
package sram_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ACQ_LO,
      ST_ACQ_HI,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_READ,
      ST_NEXT,
      ST_FINISH
   } state_t;

   localparam logic       MODE_LOAD   = 1'b0;
   localparam logic       MODE_VERIFY = 1'b1;
   localparam logic [7:0] PAD_BYTE    = 8'h00;
   localparam int         TMR_W       = 8;

   // A phase of N cycles loads N-1; the last cycle is the one where the count reads zero.
   // N=0 is clamped to a single cycle.
   function automatic logic [TMR_W-1:0] tmr_reload(input int cycles);
      if (cycles > 0) begin
         return TMR_W'(cycles - 1);
      end
      return '0;
   endfunction

endpackage

// File: rtl/sram_loader_timer.sv
// Down-counter that times the setup, strobe and read phases of an SRAM cycle.
// o_expired is high in the final cycle of the phase that was loaded.
module sram_loader_timer
   import sram_loader_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [TMR_W-1:0] i_value,
   output logic             o_expired
);

   logic [TMR_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/sram_loader.sv
// Host-side initiator for the SRAM host access port: packs a byte stream into
// 16-bit words and writes them from a base address, or re-reads a range and checksums it.
module sram_loader
   import sram_loader_pkg::*;
#(
   parameter int ADDR_W       = 18,
   parameter int SETUP_CYCLES = 1,
   parameter int WE_CYCLES    = 2,
   parameter int RD_CYCLES    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   byte_count,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic [15:0]       sum,
   output logic              jtag_jtag,
   output logic [ADDR_W-1:0] jtag_addr,
   output logic [15:0]       jtag_din,
   output logic              jtag_nwe,
   input  logic [15:0]       jtag_do
);

   localparam logic [ADDR_W:0]   TWO_BYTES = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0]   ONE_BYTE  = (ADDR_W+1)'(1);
   localparam logic [TMR_W-1:0]  SETUP_LD  = tmr_reload(SETUP_CYCLES);
   localparam logic [TMR_W-1:0]  WE_LD     = tmr_reload(WE_CYCLES);
   localparam logic [TMR_W-1:0]  RD_LD     = tmr_reload(RD_CYCLES);

   state_t            r_state;
   logic              r_mode;
   logic [ADDR_W:0]   r_remain;
   logic              r_in_ready;
   logic              r_busy;
   logic              r_done;
   logic [15:0]       r_sum;
   logic              r_jtag;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_din;
   logic              r_nwe;

   logic              w_accept;
   logic              w_last_lo;
   logic [ADDR_W:0]   w_remain_dec;
   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_value;
   logic              w_tmr_expired;

   // Byte handshake: a byte moves on any edge where in_valid and in_ready are both high.
   assign w_accept     = in_valid & r_in_ready;
   assign w_last_lo    = (r_remain == ONE_BYTE);
   assign w_remain_dec = (r_remain > TWO_BYTES) ? (r_remain - TWO_BYTES) : '0;

   // Timer loads happen on the same edges that enter a timed phase.
   always_comb begin
      w_tmr_load  = 1'b0;
      w_tmr_value = '0;
      case (r_state)
         ST_IDLE: begin
            if (start && (mode == MODE_VERIFY) && (byte_count != '0)) begin
               w_tmr_load  = 1'b1;
               w_tmr_value = RD_LD;
            end
         end
         ST_ACQ_LO: begin
            if (w_accept && w_last_lo) begin
               w_tmr_load  = 1'b1;
               w_tmr_value = SETUP_LD;
            end
         end
         ST_ACQ_HI: begin
            if (w_accept) begin
               w_tmr_load  = 1'b1;
               w_tmr_value = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (w_tmr_expired) begin
               w_tmr_load  = 1'b1;
               w_tmr_value = WE_LD;
            end
         end
         ST_NEXT: begin
            if ((w_remain_dec != '0) && (r_mode == MODE_VERIFY)) begin
               w_tmr_load  = 1'b1;
               w_tmr_value = RD_LD;
            end
         end
         default: begin
            w_tmr_load  = 1'b0;
            w_tmr_value = '0;
         end
      endcase
   end

   sram_loader_timer u_timer (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_load    (w_tmr_load),
      .i_value   (w_tmr_value),
      .o_expired (w_tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_mode     <= MODE_LOAD;
         r_remain   <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sum      <= '0;
         r_jtag     <= 1'b0;
         r_addr     <= '0;
         r_din      <= '0;
         r_nwe      <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode   <= mode;
                  r_remain <= byte_count;
                  r_sum    <= '0;
                  r_busy   <= 1'b1;
                  r_jtag   <= 1'b1;
                  r_addr   <= base_addr;
                  if (byte_count == '0) begin
                     r_state <= ST_FINISH;
                  end else if (mode == MODE_LOAD) begin
                     r_state    <= ST_ACQ_LO;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state <= ST_READ;
                  end
               end
            end
            ST_ACQ_LO: begin
               if (w_accept) begin
                  r_din[7:0] <= in_data;
                  // Odd tail: both lanes are always written, so the upper byte gets the pad.
                  if (w_last_lo) begin
                     r_din[15:8] <= PAD_BYTE;
                     r_in_ready  <= 1'b0;
                     r_state     <= ST_SETUP;
                  end else begin
                     r_state <= ST_ACQ_HI;
                  end
               end
            end
            ST_ACQ_HI: begin
               if (w_accept) begin
                  r_din[15:8] <= in_data;
                  r_in_ready  <= 1'b0;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_tmr_expired) begin
                  r_nwe   <= 1'b0;
                  r_state <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (w_tmr_expired) begin
                  r_nwe   <= 1'b1;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               r_sum   <= r_sum + r_din;
               r_state <= ST_NEXT;
            end
            ST_READ: begin
               if (w_tmr_expired) begin
                  r_sum   <= r_sum + jtag_do;
                  r_state <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               r_remain <= w_remain_dec;
               r_addr   <= r_addr + 1'b1;
               if (w_remain_dec == '0) begin
                  r_state <= ST_FINISH;
               end else if (r_mode == MODE_LOAD) begin
                  r_state    <= ST_ACQ_LO;
                  r_in_ready <= 1'b1;
               end else begin
                  r_state <= ST_READ;
               end
            end
            ST_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_jtag  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign sum       = r_sum;
   assign jtag_jtag = r_jtag;
   assign jtag_addr = r_addr;
   assign jtag_din  = r_din;
   assign jtag_nwe  = r_nwe;

endmodule

// File: tb/tb_sram_loader.sv
// Bench for sram_loader: byte-stream driver, SRAM model, write scoreboard and per-scenario tasks.
module tb_sram_loader;
   import sram_loader_pkg::*;

   localparam int ADDR_W = 18;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   byte_count;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              busy;
   logic              done;
   logic [15:0]       sum;
   logic              jtag_jtag;
   logic [ADDR_W-1:0] jtag_addr;
   logic [15:0]       jtag_din;
   logic              jtag_nwe;
   logic [15:0]       jtag_do;

   logic [15:0]        mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W+15:0] exp_q[$];
   logic [7:0]         tx_q[$];

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int nwe_pulses = 0;
   int rdy_cnt = 0;
   int stall_viol = 0;
   int low_len = 0;
   bit len_chk_en = 1'b1;
   logic prev_nwe = 1'b1;
   logic [ADDR_W-1:0] held_addr;
   logic [15:0] held_din;

   always #5 clk = ~clk;

   assign jtag_do = mem[jtag_addr];

   sram_loader #(
      .ADDR_W(ADDR_W), .SETUP_CYCLES(1), .WE_CYCLES(2), .RD_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .byte_count(byte_count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .busy(busy), .done(done), .sum(sum),
      .jtag_jtag(jtag_jtag), .jtag_addr(jtag_addr), .jtag_din(jtag_din),
      .jtag_nwe(jtag_nwe), .jtag_do(jtag_do)
   );

   // Write monitor: pops the scoreboard at each strobe start, checks pulse width and stability.
   logic [ADDR_W+15:0] mon_exp;
   always @(negedge clk) begin
      if (jtag_nwe === 1'b0) begin
         if (prev_nwe === 1'b1) begin
            nwe_pulses++;
            low_len = 1;
            held_addr = jtag_addr;
            held_din = jtag_din;
            mem[jtag_addr] = jtag_din;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL write_unexpected: got addr=%h data=%h, expected no write", jtag_addr, jtag_din);
            end else begin
               mon_exp = exp_q.pop_front();
               if ({jtag_addr, jtag_din} !== mon_exp) begin
                  n_fail++;
                  $display("FAIL write_word: got addr=%h data=%h, expected addr=%h data=%h",
                           jtag_addr, jtag_din, mon_exp[ADDR_W+15:16], mon_exp[15:0]);
               end
            end
         end else begin
            low_len++;
            n_checks++;
            if ({jtag_addr, jtag_din} !== {held_addr, held_din}) begin
               n_fail++;
               $display("FAIL strobe_stable: got addr=%h data=%h, expected addr=%h data=%h",
                        jtag_addr, jtag_din, held_addr, held_din);
            end
         end
      end else if (prev_nwe === 1'b0 && len_chk_en) begin
         n_checks++;
         if (low_len != 2) begin
            n_fail++;
            $display("FAIL nwe_width: got %0d cycles, expected 2", low_len);
         end
      end
      prev_nwe = jtag_nwe;
      if (done === 1'b1) done_cnt++;
      if (in_ready === 1'b1) rdy_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; byte_count = '0;
      in_valid = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_xfer(input logic m, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
      @(negedge clk);
      start = 1'b1; mode = m; base_addr = b; byte_count = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Sends tx_q; with backpressure, in_valid is low 3 cycles then high 3 cycles.
   task automatic send_bytes(input bit bp, output bit ok);
      int idx = 0;
      int cyc = 0;
      bit v;
      while (idx < tx_q.size() && cyc < 4000) begin
         v = bp ? (((cyc / 3) % 2) == 1) : 1'b1;
         if ((idx % 2) == 1 && jtag_nwe !== 1'b1) stall_viol++;
         in_valid = v;
         in_data = tx_q[idx];
         if (v && in_ready === 1'b1) idx++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      ok = (idx == tx_q.size());
   endtask

   task automatic wait_done(output bit ok);
      int k = 0;
      while (done !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      ok = (done === 1'b1);
   endtask

   // Model: packs tx_q little-endian with zero pad, pushes expected writes, returns checksum.
   task automatic push_expect(input logic [ADDR_W-1:0] base, input int count, output logic [15:0] s);
      logic [15:0] w;
      logic [ADDR_W-1:0] a;
      s = '0;
      a = base;
      for (int i = 0; i < count; i += 2) begin
         w[7:0] = tx_q[i];
         w[15:8] = (i + 1 < count) ? tx_q[i+1] : 8'h00;
         exp_q.push_back({a, w});
         s = s + w;
         a = a + 1'b1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
      n_checks++; if (sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h, expected 0000", sum); end
      n_checks++; if (jtag_jtag !== 1'b0) begin n_fail++; $display("FAIL reset_jtag: got %b, expected 0", jtag_jtag); end
      n_checks++; if (jtag_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0", jtag_addr); end
      n_checks++; if (jtag_din !== 16'h0) begin n_fail++; $display("FAIL reset_din: got %h, expected 0000", jtag_din); end
      n_checks++; if (jtag_nwe !== 1'b1) begin n_fail++; $display("FAIL reset_nwe: got %b, expected 1", jtag_nwe); end
   endtask

   task automatic run_load(input string name, input logic [ADDR_W-1:0] base, input int count, input bit bp);
      logic [15:0] exp_sum;
      int p0, d0;
      bit ok;
      push_expect(base, count, exp_sum);
      p0 = nwe_pulses; d0 = done_cnt;
      start_xfer(MODE_LOAD, base, count[ADDR_W:0]);
      send_bytes(bp, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_bytes: got accepted=0, expected all bytes accepted", name); end
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_done_timeout: got no done, expected done", name); end
      n_checks++; if (sum !== exp_sum) begin n_fail++; $display("FAIL %s_sum: got %h, expected %h", name, sum, exp_sum); end
      n_checks++; if (busy !== 1'b0 || jtag_jtag !== 1'b0) begin n_fail++; $display("FAIL %s_release: got busy=%b jtag=%b, expected 0 0", name, busy, jtag_jtag); end
      repeat (3) @(negedge clk);
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d, expected 1", name, done_cnt - d0); end
      n_checks++; if (nwe_pulses - p0 != (count + 1) / 2) begin n_fail++; $display("FAIL %s_nwe_pulses: got %0d, expected %0d", name, nwe_pulses - p0, (count + 1) / 2); end
      n_checks++; if (sum !== exp_sum) begin n_fail++; $display("FAIL %s_sum_hold: got %h, expected %h", name, sum, exp_sum); end
   endtask

   task automatic test_load_basic();
      logic [15:0] exp_sum;
      int d0;
      bit ok;
      tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      push_expect(18'h00100, 4, exp_sum);
      n_checks++; if (exp_sum !== 16'h6644) begin n_fail++; $display("FAIL basic_model_sum: got %h, expected 6644", exp_sum); end
      d0 = done_cnt;
      start_xfer(MODE_LOAD, 18'h00100, 19'd4);
      // A start while busy must be ignored.
      start = 1'b1; mode = MODE_VERIFY; base_addr = 18'h03000; byte_count = '0;
      @(negedge clk);
      start = 1'b0;
      send_bytes(1'b0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_bytes: got accepted=0, expected 1"); end
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no done, expected done"); end
      n_checks++; if (sum !== 16'h6644) begin n_fail++; $display("FAIL basic_sum: got %h, expected 6644", sum); end
      repeat (3) @(negedge clk);
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, expected 1", done_cnt - d0); end
   endtask

   task automatic test_load_odd();
      tx_q = '{8'hAA, 8'hBB, 8'hCC};
      run_load("odd", 18'h00000, 3, 1'b0);
      n_checks++; if (sum !== 16'hBC76) begin n_fail++; $display("FAIL odd_sum_const: got %h, expected bc76", sum); end
   endtask

   task automatic test_verify_wrap();
      int p0, r0, d0;
      bit ok;
      mem[18'h3FFFF] = 16'h1234;
      mem[18'h00000] = 16'h0001;
      p0 = nwe_pulses; r0 = rdy_cnt; d0 = done_cnt;
      start_xfer(MODE_VERIFY, 18'h3FFFF, 19'd4);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL verify_done_timeout: got no done, expected done"); end
      n_checks++; if (sum !== 16'h1235) begin n_fail++; $display("FAIL verify_sum: got %h, expected 1235", sum); end
      n_checks++; if (jtag_addr !== 18'h00001) begin n_fail++; $display("FAIL verify_addr_wrap: got %h, expected 00001", jtag_addr); end
      repeat (3) @(negedge clk);
      n_checks++; if (nwe_pulses != p0) begin n_fail++; $display("FAIL verify_no_write: got %0d pulses, expected 0", nwe_pulses - p0); end
      n_checks++; if (rdy_cnt != r0) begin n_fail++; $display("FAIL verify_no_ready: got %0d ready cycles, expected 0", rdy_cnt - r0); end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL verify_done_pulses: got %0d, expected 1", done_cnt - d0); end
   endtask

   task automatic test_backpressure();
      stall_viol = 0;
      tx_q = '{8'h01, 8'h80, 8'h7F, 8'hFE, 8'h5A, 8'hC3};
      run_load("bp", 18'h02000, 6, 1'b1);
      n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_early_strobe: got %0d, expected 0", stall_viol); end
   endtask

   task automatic test_zero_count();
      int p0;
      p0 = nwe_pulses;
      start_xfer(MODE_LOAD, 18'h00055, 19'd0);
      n_checks++; if (done !== 1'b0 || busy !== 1'b1 || jtag_jtag !== 1'b1) begin n_fail++; $display("FAIL zero_finish_cycle: got done=%b busy=%b jtag=%b, expected 0 1 1", done, busy, jtag_jtag); end
      @(negedge clk);
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || jtag_jtag !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b jtag=%b, expected 1 0 0", done, busy, jtag_jtag); end
      n_checks++; if (sum !== 16'h0) begin n_fail++; $display("FAIL zero_sum: got %h, expected 0000", sum); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b, expected 0", done); end
      n_checks++; if (nwe_pulses != p0) begin n_fail++; $display("FAIL zero_no_write: got %0d pulses, expected 0", nwe_pulses - p0); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp_sum;
      int d0, k;
      bit ok;
      tx_q = '{8'h5A, 8'hA5};
      push_expect(18'h00040, 2, exp_sum);
      d0 = done_cnt;
      start_xfer(MODE_LOAD, 18'h00040, 19'd2);
      send_bytes(1'b0, ok);
      k = 0;
      while (jtag_nwe !== 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++; if (jtag_nwe !== 1'b0) begin n_fail++; $display("FAIL abort_reach_strobe: got nwe=%b, expected 0", jtag_nwe); end
      len_chk_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (jtag_nwe !== 1'b1 || jtag_jtag !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_state: got nwe=%b jtag=%b busy=%b, expected 1 0 0", jtag_nwe, jtag_jtag, busy); end
      n_checks++; if (sum !== 16'h0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got sum=%h ready=%b, expected 0000 0", sum, in_ready); end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      len_chk_en = 1'b1;
      n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, expected 0", done_cnt - d0); end
      tx_q = '{8'h3C, 8'hC3};
      run_load("after_abort", 18'h00041, 2, 1'b0);
   endtask

   task automatic test_random();
      int cnt;
      logic [ADDR_W-1:0] b;
      for (int it = 0; it < 4; it++) begin
         cnt = $urandom_range(1, 9);
         b = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
         tx_q.delete();
         for (int i = 0; i < cnt; i++) tx_q.push_back(8'($urandom_range(0, 255)));
         run_load("random", b, cnt, it[0]);
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_load_basic();
      test_load_odd();
      test_verify_wrap();
      test_backpressure();
      test_zero_count();
      test_reset_mid();
      test_random();
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
